lim_dport_bridge: RTL and testbench
===================================

Name: lim_dport_bridge

Overview:
- Upstream stage of the logic-in-memory racetrack data port, between the core LSU (req/gnt/rvalid protocol) and the LiM memory's port B (en_b/gnt_b/rvalid_b).
- Serialises core data accesses into single memory transactions and holds them until the memory's variable racetrack latency completes.
- Services LiM function-cell writes and reads locally, keeps a shadow copy of the function cell, and flags out-of-range accesses.

Parameters:
- ADDR_WIDTH, 17, width of the memory-side byte address.
- MAX_SIZE, 32768, memory size in bytes; data addresses at or above this are out of range.
- FUNCT_ADDR, 32'h0001fffc, LiM function-cell programming address.
- TIMEOUT_CYCLES, 1024, watchdog limit; only used with LIM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, single domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  core grant.
- data_addr_i  in  32  core byte address.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  store data, or LiM mask.
- data_rvalid_o  out  1  response valid, one-cycle pulse.
- data_rdata_o  out  32  response data.
- data_err_o  out  1  response error, qualified by data_rvalid_o.
- mem_en_b_o  out  1  memory request pulse.
- mem_addr_b_o  out  ADDR_WIDTH  word-aligned memory address.
- mem_we_b_o  out  1  memory write enable.
- mem_be_b_o  out  4  memory byte enables.
- mem_wdata_b_o  out  32  memory write data.
- mem_gnt_b_o  out  1  grant to memory; drives its rvalid on function-cell writes.
- mem_rdata_b_i  in  32  memory read data.
- mem_rvalid_b_i  in  1  memory transaction complete.
- lim_funct_o  out  32  shadow of the function cell: [31:8] asize, [7:0] opcode.
- range_o  out  1  next access is a LiM range operation (asize not 0 and not 1).
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, lim_funct_o 0, FSM in IDLE. An asynchronous reset mid-transaction aborts it; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - data_gnt_o = data_req_i (combinational). Grant is never asserted in any other state.
  - On grant, latch addr, we, be and wdata, then go to ISSUE.
- ISSUE (exactly one cycle), with the access classified from the latched address:
  - Function-cell write (we && addr == FUNCT_ADDR): mem_en_b_o=1, mem_gnt_b_o=1, mem_addr_b_o = FUNCT_ADDR[ADDR_WIDTH-1:0]. lim_funct_o <= wdata at the clock edge. Go to RESP with err=0 and rdata=0.
  - Function-cell read: no memory access. rdata <= lim_funct_o. Go to RESP.
  - Out of range (addr >= MAX_SIZE, not FUNCT_ADDR): no memory access. Go to RESP with err=1 and rdata=0.
  - Normal access: mem_en_b_o=1 for this cycle only, mem_addr_b_o = {addr[ADDR_WIDTH-1:2],2'b00}. If mem_rvalid_b_i is already 1 this cycle, capture the data and go to RESP; otherwise go to WAIT.
- WAIT:
  - mem_addr_b_o, mem_we_b_o, mem_be_b_o and mem_wdata_b_o stay stable; mem_en_b_o=0.
  - On mem_rvalid_b_i, capture mem_rdata_b_i and go to RESP. In range mode the memory asserts rvalid only on the last element; the bridge waits unconditionally.
- RESP: data_rvalid_o=1 for one cycle, with data_rdata_o and data_err_o valid. Return to IDLE.
- Latency: grant at cycle 0, issue at cycle 1.
  - Memory rvalid at cycle k ≥ 1 gives data_rvalid_o at k+1.
  - Function-cell and error responses arrive at cycle 2.
  - Back-to-back requests run at a minimum of one per 3 cycles.
- mem_rvalid_b_i outside ISSUE and WAIT is ignored.
- range_o = (lim_funct_o[31:8] > 1), registered with lim_funct_o.
- data_addr_i[1:0] is ignored; sub-word selection uses be only.

Optional Feature:
- Macro LIM_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without mem_rvalid_b_i, go to RESP with err=1 and rdata=0.
  - A late mem_rvalid_b_i then arrives in IDLE and is ignored.
- Undefined: no counter; WAIT is held indefinitely, and data_err_o is raised only for out-of-range accesses.

Test Plan:
- Write 32'h00000401 to 0x1fffc → mem_en_b_o and mem_gnt_b_o high together in cycle 1; data_rvalid_o in cycle 2 with err=0; lim_funct_o = 0x00000401, range_o=1.
- Load from 0x100 with memory rvalid 5 cycles after issue → mem_addr_b_o = 0x100 held stable through WAIT; one mem_en_b_o pulse; data_rvalid_o exactly one cycle after mem_rvalid_b_i, returning mem_rdata_b_i.
- Load from 0x8000 (= MAX_SIZE) → no mem_en_b_o; data_rvalid_o at cycle 2 with err=1, rdata=0.
- Read of 0x1fffc after the write above → no memory access; rdata = 0x00000401.
- Assert rst_ni=0 during WAIT → all outputs 0 immediately, no data_rvalid_o, lim_funct_o=0; the next request behaves normally.
- LIM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and memory never responding → err=1 response 8 cycles after entering WAIT; a later stray mem_rvalid_b_i produces no data_rvalid_o.

Source files
------------

// File: rtl/lim_dport_bridge.sv
// Upstream bridge between the core LSU and port B of the LiM racetrack memory.
// Optional watchdog on the memory wait is enabled with LIM_TIMEOUT_EN.
module lim_dport_bridge #(
    parameter int unsigned ADDR_WIDTH     = 17,
    parameter int unsigned MAX_SIZE       = 32768,
    parameter logic [31:0] FUNCT_ADDR     = 32'h0001fffc,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    output logic                  mem_en_b_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_b_o,
    output logic                  mem_we_b_o,
    output logic [3:0]            mem_be_b_o,
    output logic [31:0]           mem_wdata_b_o,
    output logic                  mem_gnt_b_o,
    input  logic [31:0]           mem_rdata_b_i,
    input  logic                  mem_rvalid_b_i,
    output logic [31:0]           lim_funct_o,
    output logic                  range_o,
    output logic                  busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [31:0] MAX_SIZE_C = MAX_SIZE;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [29:0] addr_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [31:0] funct_r;
    logic        range_r;

    logic        is_funct_s;
    logic        is_oor_s;
    logic        is_fwrite_s;
    logic        is_normal_s;
    logic        timeout_s;
    logic        rsp_load_s;
    logic [31:0] rsp_data_s;
    logic        rsp_err_s;
    logic        unused_addr_lsb_s;

    // The byte offset never takes part in decoding; lanes are chosen by be.
    assign unused_addr_lsb_s = ^data_addr_i[1:0];

    assign is_funct_s  = (addr_r == FUNCT_ADDR[31:2]);
    assign is_oor_s    = !is_funct_s && ({addr_r, 2'b00} >= MAX_SIZE_C);
    assign is_fwrite_s = is_funct_s && we_r;
    assign is_normal_s = !is_funct_s && !is_oor_s;

    assign data_gnt_o    = (state_r == ST_IDLE) && data_req_i;
    assign mem_en_b_o    = (state_r == ST_ISSUE) && (is_fwrite_s || is_normal_s);
    assign mem_gnt_b_o   = (state_r == ST_ISSUE) && is_fwrite_s;
    assign mem_addr_b_o  = {addr_r[ADDR_WIDTH-3:0], 2'b00};
    assign mem_we_b_o    = we_r;
    assign mem_be_b_o    = be_r;
    assign mem_wdata_b_o = wdata_r;
    assign data_rvalid_o = (state_r == ST_RESP);
    assign data_rdata_o  = rdata_r;
    assign data_err_o    = err_r;
    assign lim_funct_o   = funct_r;
    assign range_o       = range_r;
    assign busy_o        = (state_r != ST_IDLE);

`ifdef LIM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // Wait-cycle counter; held at zero outside WAIT so each entry starts fresh
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && !mem_rvalid_b_i &&
                       (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = TIMEOUT_CYCLES;
    assign timeout_s        = 1'b0;
`endif

    // Next state and the response payload to capture when leaving ISSUE/WAIT
    always_comb begin
        state_nxt_s = state_r;
        rsp_load_s  = 1'b0;
        rsp_data_s  = 32'h0000_0000;
        rsp_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_req_i) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (is_funct_s) begin
                    state_nxt_s = ST_RESP;
                    rsp_load_s  = 1'b1;
                    rsp_data_s  = we_r ? 32'h0000_0000 : funct_r;
                end else if (is_oor_s) begin
                    state_nxt_s = ST_RESP;
                    rsp_load_s  = 1'b1;
                    rsp_err_s   = 1'b1;
                end else if (mem_rvalid_b_i) begin
                    state_nxt_s = ST_RESP;
                    rsp_load_s  = 1'b1;
                    rsp_data_s  = mem_rdata_b_i;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Range operations only signal completion on their last element.
                if (mem_rvalid_b_i) begin
                    state_nxt_s = ST_RESP;
                    rsp_load_s  = 1'b1;
                    rsp_data_s  = mem_rdata_b_i;
                end else if (timeout_s) begin
                    state_nxt_s = ST_RESP;
                    rsp_load_s  = 1'b1;
                    rsp_err_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch, loaded only on grant so memory-side outputs stay stable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r  <= 30'h0000_0000;
            we_r    <= 1'b0;
            be_r    <= 4'h0;
            wdata_r <= 32'h0000_0000;
        end else if (data_gnt_o) begin
            addr_r  <= data_addr_i[31:2];
            we_r    <= data_we_i;
            be_r    <= data_be_i;
            wdata_r <= data_wdata_i;
        end
    end

    // Response data/error register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (rsp_load_s) begin
            rdata_r <= rsp_data_s;
            err_r   <= rsp_err_s;
        end
    end

    // Shadow of the function cell and its derived range flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            funct_r <= 32'h0000_0000;
            range_r <= 1'b0;
        end else if ((state_r == ST_ISSUE) && is_fwrite_s) begin
            funct_r <= wdata_r;
            range_r <= (wdata_r[31:8] > 24'd1);
        end
    end

endmodule

// File: tb/tb_lim_dport_bridge.sv
// Randomised bench for lim_dport_bridge against a transaction-level model of
// the core-visible behaviour and a simple word-addressed memory.
module tb_lim_dport_bridge;

    localparam int          TO        = 8;
    localparam logic [31:0] FUNCT     = 32'h0001fffc;
    localparam logic [31:0] MAX_BYTES = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req = 1'b0;
    logic        data_gnt;
    logic [31:0] data_addr = 32'h0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        mem_en;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] lim_funct;
    logic        range_flag;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_arr [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic [31:0] model_funct = 32'h0;

    lim_dport_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
        .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .mem_en_b_o(mem_en), .mem_addr_b_o(mem_addr), .mem_we_b_o(mem_we),
        .mem_be_b_o(mem_be), .mem_wdata_b_o(mem_wdata), .mem_gnt_b_o(mem_gnt),
        .mem_rdata_b_i(mem_rdata), .mem_rvalid_b_i(mem_rvalid),
        .lim_funct_o(lim_funct), .range_o(range_flag), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // One core access; k is the cycle (after grant) in which memory completes.
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input int k);
        bit          is_f, is_oor, is_norm, seen, addr_moved, gnt_seen, never;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc, en_cnt, mgnt_cnt, cyc;
        logic [16:0] first_addr;
        logic [12:0] midx;

        is_f    = (a[31:2] == FUNCT[31:2]);
        is_oor  = !is_f && (a >= MAX_BYTES);
        is_norm = !is_f && !is_oor;
        never   = (k > 30);
        exp_err = 1'b0;
        exp_cyc = 2;
        exp_rdata = 32'h0;
        if (is_f) begin
            if (w) model_funct = d;
            else   exp_rdata = model_funct;
        end else if (is_oor) begin
            exp_err = 1'b1;
        end else if (never) begin
            exp_err = 1'b1;
            exp_cyc = 2 + TO;
        end else begin
            if (w) ref_mem[a[14:2]] = merge(ref_mem[a[14:2]], d, b);
            exp_rdata = ref_mem[a[14:2]];
            exp_cyc   = k + 1;
        end

        @(posedge clk); #1;
        data_req = 1'b1; data_addr = a; data_we = w; data_be = b; data_wdata = d;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("grant", 32'(data_gnt), 32'h1);
        check_val("busy_idle", 32'(busy), 32'h0);

        seen = 0; addr_moved = 0; gnt_seen = 0;
        en_cnt = 0; mgnt_cnt = 0; midx = 13'h0; first_addr = 17'h0;
        for (cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(posedge clk); #1;
            data_addr = $urandom; data_wdata = $urandom; data_we = 1'($urandom);
            if (is_norm) mem_rvalid = (cyc == k) || (cyc > k && $urandom_range(0, 1) == 1);
            else         mem_rvalid = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (data_gnt) gnt_seen = 1;
            if (mem_gnt) mgnt_cnt++;
            if (mem_en) begin
                en_cnt++;
                first_addr = mem_addr;
                if (!mem_gnt) begin
                    midx = mem_addr[14:2];
                    if (mem_we) mem_arr[midx] = merge(mem_arr[midx], mem_wdata, mem_be);
                end
            end
            if (cyc > 1 && is_norm && busy && !data_rvalid && mem_addr != first_addr)
                addr_moved = 1;
            mem_rdata = mem_arr[midx];
            if (data_rvalid) begin
                seen = 1;
                check_val("rsp_cycle", 32'(cyc), 32'(exp_cyc));
                check_val("rsp_rdata", data_rdata, exp_rdata);
                check_val("rsp_err", 32'(data_err), 32'(exp_err));
                data_req = 1'b0;
                mem_rvalid = 1'b0;
            end
        end
        if (!seen) begin
            check_val("rsp_timeout", 32'h0, 32'h1);
            data_req = 1'b0;
        end
        check_val("gnt_while_busy", 32'(gnt_seen), 32'h0);
        check_val("mem_en_count", 32'(en_cnt), 32'((is_f && w) || is_norm));
        check_val("mem_gnt_count", 32'(mgnt_cnt), 32'(is_f && w));
        if ((is_f && w) || is_norm) begin
            check_val("mem_addr", 32'(first_addr), {15'h0, a[16:2], 2'b00});
            check_val("mem_addr_stable", 32'(addr_moved), 32'h0);
        end
        check_val("lim_funct", lim_funct, model_funct);
        check_val("range", 32'(range_flag), 32'(model_funct[31:8] > 24'd1));
    endtask

    // Idle cycles with stray memory completions that must be ignored.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_req = 1'b0;
            mem_rvalid = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check_val("idle_no_rvalid", 32'(data_rvalid), 32'h0);
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic reset_in_wait();
        @(posedge clk); #1;
        data_req = 1'b1; data_addr = 32'h200; data_we = 1'b0; data_be = 4'hf;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        data_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("busy_in_wait", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("rst_rvalid", 32'(data_rvalid), 32'h0);
        check_val("rst_mem_en", 32'(mem_en), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_funct", lim_funct, 32'h0);
        check_val("rst_range", 32'(range_flag), 32'h0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_val("rst_gnt", 32'(data_gnt), 32'h0);
        model_funct = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 8192; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        check_val("reset_busy", 32'(busy), 32'h0);
        check_val("reset_rvalid", 32'(data_rvalid), 32'h0);
        check_val("reset_funct", lim_funct, 32'h0);
        check_val("reset_mem_en", 32'(mem_en), 32'h0);
        rst_n = 1'b1;
        idle_cycles(2);

        access(32'h0001fffc, 1'b1, 4'hf, 32'h00000401, 1);
        access(32'h00000100, 1'b0, 4'hf, 32'h0, 6);
        access(32'h00000100, 1'b1, 4'h5, 32'hdeadbeef, 1);
        access(32'h00000103, 1'b0, 4'hf, 32'h0, 2);
        access(32'h00008000, 1'b0, 4'hf, 32'h0, 1);
        access(32'h0001fffc, 1'b0, 4'hf, 32'h0, 1);
        access(32'h0001fffc, 1'b1, 4'hf, 32'h00000105, 1);
        reset_in_wait();
        access(32'h00000100, 1'b0, 4'hf, 32'h0, 3);
        access(32'h0001fffc, 1'b0, 4'hf, 32'h0, 1);
`ifdef LIM_TIMEOUT_EN
        access(32'h00000300, 1'b0, 4'hf, 32'h0, 99);
        idle_cycles(3);
`endif

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    a = FUNCT;
                2, 3:    a = MAX_BYTES + 32'($urandom_range(0, 32'h000f_ffff));
                default: a = 32'($urandom_range(0, 32'h7fff));
            endcase
            access(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
